// File: rtl/p_encoder_drain.sv
// Sequential priority encoder: captures a request vector and drains it highest index first.
// Define P_ENC_MERGE_EN to let new requests merge into the pending set while it drains.
module p_encoder_drain #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_in,
  input  logic             req_load,
  output logic             load_rdy,
  output logic [IDX_W-1:0] idx_out,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic             done,
  output logic [WIDTH-1:0] pend_out
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] msb_idx;
  logic [WIDTH-1:0] served;
  logic             xfer;

  // NOTE: async reset in the sensitivity list; every register here is small, so all get a reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  // Ascending scan, so the last set bit seen (the MSB) wins.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pend_q[i]) msb_idx = IDX_W'(i);
    end
  end

  assign xfer   = (state_q == DRAIN) && idx_ready;
  assign served = xfer ? (WIDTH'(1) << msb_idx) : '0;

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_load && (req_in != '0)) begin
          pend_d  = req_in;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        pend_d = pend_q & ~served;
`ifdef P_ENC_MERGE_EN
        if (req_load) pend_d = pend_d | req_in;
`endif
        if (pend_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_comb begin
    idx_valid = (state_q == DRAIN);
    idx_out   = idx_valid ? msb_idx : '0;
`ifdef P_ENC_MERGE_EN
    load_rdy  = 1'b1;
`else
    load_rdy  = (state_q == IDLE);
`endif
    done      = done_q;
    pend_out  = pend_q;
  end

endmodule

// File: tb/tb_p_encoder_drain.sv
// Directed self-checking bench for p_encoder_drain at WIDTH 8, 16 and 1.
module tb_p_encoder_drain;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 8 instance
  logic [7:0] req8 = '0;
  logic       load8 = 1'b0, rdy8 = 1'b0;
  logic       lrdy8, valid8, done8;
  logic [2:0] idx8;
  logic [7:0] pend8;

  // WIDTH = 16 instance
  logic [15:0] req16 = '0;
  logic        load16 = 1'b0, rdy16 = 1'b0;
  logic        lrdy16, valid16, done16;
  logic [3:0]  idx16;
  logic [15:0] pend16;

  // WIDTH = 1 instance
  logic [0:0] req1 = '0;
  logic       load1 = 1'b0, rdy1 = 1'b0;
  logic       lrdy1, valid1, done1;
  logic [0:0] idx1;
  logic [0:0] pend1;

  p_encoder_drain #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req_in(req8), .req_load(load8), .load_rdy(lrdy8),
    .idx_out(idx8), .idx_valid(valid8), .idx_ready(rdy8), .done(done8), .pend_out(pend8)
  );

  p_encoder_drain #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .req_in(req16), .req_load(load16), .load_rdy(lrdy16),
    .idx_out(idx16), .idx_valid(valid16), .idx_ready(rdy16), .done(done16), .pend_out(pend16)
  );

  p_encoder_drain #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_in(req1), .req_load(load1), .load_rdy(lrdy1),
    .idx_out(idx1), .idx_valid(valid1), .idx_ready(rdy1), .done(done1), .pend_out(pend1)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    step();
    check("rst_valid", 32'(valid8), 32'd0);
    check("rst_idx", 32'(idx8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_lrdy", 32'(lrdy8), 32'd1);
    check("rst_pend", 32'(pend8), 32'h0);
    rst_n = 1'b1;

    // Load A4, drain 7,5,2 then done
    step();
    req8 = 8'hA4; load8 = 1'b1; rdy8 = 1'b1;
    step();
    load8 = 1'b0;
    check("a4_idx0", 32'(idx8), 32'd7);
    check("a4_val0", 32'(valid8), 32'd1);
    check("a4_pend0", 32'(pend8), 32'hA4);
    step();
    check("a4_idx1", 32'(idx8), 32'd5);
    check("a4_pend1", 32'(pend8), 32'h24);
    step();
    check("a4_idx2", 32'(idx8), 32'd2);
    check("a4_done_early", 32'(done8), 32'd0);
    step();
    check("a4_done", 32'(done8), 32'd1);
    check("a4_val_end", 32'(valid8), 32'd0);
    check("a4_lrdy_end", 32'(lrdy8), 32'd1);
    check("a4_pend_end", 32'(pend8), 32'h0);
    step();
    check("a4_done_off", 32'(done8), 32'd0);

    // Load 81 with stall for three cycles
    req8 = 8'h81; load8 = 1'b1; rdy8 = 1'b0;
    step();
    load8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_idx", 32'(idx8), 32'd7);
      check("stall_val", 32'(valid8), 32'd1);
      check("stall_pend", 32'(pend8), 32'h81);
      step();
    end
    check("stall_idx_last", 32'(idx8), 32'd7);
    rdy8 = 1'b1;
    step();
    check("stall_idx1", 32'(idx8), 32'd0);
    check("stall_pend1", 32'(pend8), 32'h01);
    step();
    check("stall_done", 32'(done8), 32'd1);
    step();

    // Zero load is ignored, then back-to-back load of 10
    req8 = 8'h00; load8 = 1'b1;
    step();
    check("zero_val", 32'(valid8), 32'd0);
    check("zero_lrdy", 32'(lrdy8), 32'd1);
    check("zero_pend", 32'(pend8), 32'h0);
    req8 = 8'h10;
    step();
    load8 = 1'b0;
    check("zero_done", 32'(done8), 32'd0);
    check("b2b_idx", 32'(idx8), 32'd4);
    check("b2b_val", 32'(valid8), 32'd1);
    step();
    check("b2b_done", 32'(done8), 32'd1);
    step();

    // Load during DRAIN: pend = 04, req_in = 40
    req8 = 8'h04; load8 = 1'b1; rdy8 = 1'b0;
    step();
    check("mrg_idx_pre", 32'(idx8), 32'd2);
`ifdef P_ENC_MERGE_EN
    check("mrg_lrdy", 32'(lrdy8), 32'd1);
`else
    check("mrg_lrdy", 32'(lrdy8), 32'd0);
`endif
    req8 = 8'h40;
    step();
    load8 = 1'b0; rdy8 = 1'b1;
`ifdef P_ENC_MERGE_EN
    check("mrg_idx0", 32'(idx8), 32'd6);
    check("mrg_pend0", 32'(pend8), 32'h44);
    step();
    check("mrg_idx1", 32'(idx8), 32'd2);
`else
    check("mrg_idx0", 32'(idx8), 32'd2);
    check("mrg_pend0", 32'(pend8), 32'h04);
`endif
    step();
    check("mrg_done", 32'(done8), 32'd1);
    check("mrg_val_end", 32'(valid8), 32'd0);
    step();

    // Asynchronous reset mid-drain of F0
    req8 = 8'hF0; load8 = 1'b1; rdy8 = 1'b1;
    step();
    load8 = 1'b0;
    check("ar_idx0", 32'(idx8), 32'd7);
    step();
    check("ar_pend1", 32'(pend8), 32'h70);
    #1 rst_n = 1'b0;
    #2;
    check("ar_val", 32'(valid8), 32'd0);
    check("ar_idx", 32'(idx8), 32'd0);
    check("ar_pend", 32'(pend8), 32'h0);
    check("ar_lrdy", 32'(lrdy8), 32'd1);
    check("ar_done", 32'(done8), 32'd0);
    step();
    check("ar_done_hold", 32'(done8), 32'd0);
    rst_n = 1'b1;
    req8 = 8'h01; load8 = 1'b1;
    step();
    load8 = 1'b0;
    check("ar_first_val", 32'(valid8), 32'd1);
    check("ar_first_idx", 32'(idx8), 32'd0);
    step();
    check("ar_first_done", 32'(done8), 32'd1);
    step();

    // WIDTH = 16 and WIDTH = 1 instances
    req16 = 16'h8001; load16 = 1'b1; rdy16 = 1'b1;
    req1 = 1'b1; load1 = 1'b1; rdy1 = 1'b1;
    step();
    load16 = 1'b0; load1 = 1'b0;
    check("w16_idx0", 32'(idx16), 32'd15);
    check("w16_val0", 32'(valid16), 32'd1);
    check("w1_idx", 32'(idx1), 32'd0);
    check("w1_val", 32'(valid1), 32'd1);
    check("w1_pend", 32'(pend1), 32'd1);
    step();
    check("w16_idx1", 32'(idx16), 32'd0);
    check("w16_pend1", 32'(pend16), 32'h0001);
    check("w1_done", 32'(done1), 32'd1);
    check("w1_val_end", 32'(valid1), 32'd0);
    step();
    check("w16_done", 32'(done16), 32'd1);
    check("w16_val_end", 32'(valid16), 32'd0);
    check("w1_done_off", 32'(done1), 32'd0);
    step();
    check("w16_done_off", 32'(done16), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
